// File: rtl/mem_responder.sv
// Memory-backed request/response endpoint: reads/writes a word array on request
// acceptance and returns an in-order response after a fixed minimum latency.
module mem_responder #(
  parameter int p_addr_bits = 32,
  parameter int p_data_bits = 32,
  parameter int p_opaq_bits = 8,
  parameter int p_mem_words = 256,
  parameter int p_latency   = 2,
  parameter int p_depth     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic                   req_op,
  input  logic [p_opaq_bits-1:0] req_opaque,
  input  logic [p_addr_bits-1:0] req_addr,
  input  logic [1:0]             req_len,
  input  logic [p_data_bits-1:0] req_data,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic                   resp_op,
  output logic [p_opaq_bits-1:0] resp_opaque,
  output logic [p_addr_bits-1:0] resp_addr,
  output logic [1:0]             resp_len,
  output logic [p_data_bits-1:0] resp_data
);

  localparam int IDX_BITS  = $clog2(p_mem_words);
  localparam int QIDX_BITS = $clog2(p_depth);
  localparam int PTR_BITS  = QIDX_BITS + 1;
  localparam int NBYTES    = p_data_bits / 8;
  localparam logic [PTR_BITS-1:0] DEPTH_PTR = PTR_BITS'(p_depth);
  localparam logic [2:0]          LOAD_CNT  = 3'(p_latency - 1);

  logic [p_data_bits-1:0] r_mem [p_mem_words];

  logic                   r_q_op     [p_depth];
  logic [p_opaq_bits-1:0] r_q_opaque [p_depth];
  logic [p_addr_bits-1:0] r_q_addr   [p_depth];
  logic [1:0]             r_q_len    [p_depth];
  logic [p_data_bits-1:0] r_q_data   [p_depth];
  logic [2:0]             r_q_cnt    [p_depth];

  logic [PTR_BITS-1:0]  r_wr_ptr;
  logic [PTR_BITS-1:0]  r_rd_ptr;
  logic [PTR_BITS-1:0]  w_count;
  logic [QIDX_BITS-1:0] w_wr_idx;
  logic [QIDX_BITS-1:0] w_rd_idx;
  logic [IDX_BITS-1:0]  w_word_idx;
  logic [NBYTES-1:0]    w_byte_en;
  logic                 w_push;
  logic                 w_pop;

  assign w_word_idx = req_addr[IDX_BITS+1:2];
  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_wr_idx   = r_wr_ptr[QIDX_BITS-1:0];
  assign w_rd_idx   = r_rd_ptr[QIDX_BITS-1:0];

  // Gated by rst so the port reads 0 while in reset and 1 as soon as it releases.
  assign req_rdy  = rst & (w_count < DEPTH_PTR);
  assign w_push   = req_val & req_rdy;
  assign resp_val = (w_count != '0) && (r_q_cnt[w_rd_idx] == 3'd0);
  assign w_pop    = resp_val & resp_rdy;

  assign resp_op     = r_q_op[w_rd_idx];
  assign resp_opaque = r_q_opaque[w_rd_idx];
  assign resp_addr   = r_q_addr[w_rd_idx];
  assign resp_len    = r_q_len[w_rd_idx];
  assign resp_data   = r_q_data[w_rd_idx];

  // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_byte_en = '0;
    for (int b = 0; b < NBYTES; b++) begin
      w_byte_en[b] = (req_len == 2'd0) || (b < int'(req_len));
    end
  end

  // NOTE: memory and queue payload carry no reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (w_push && req_op) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (w_byte_en[b]) begin
          r_mem[w_word_idx][8*b +: 8] <= req_data[8*b +: 8];
        end
      end
    end
  end

  // Read data is sampled before this edge's write lands; a write and a read never share an edge.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_op[w_wr_idx]     <= req_op;
      r_q_opaque[w_wr_idx] <= req_opaque;
      r_q_addr[w_wr_idx]   <= req_addr;
      r_q_len[w_wr_idx]    <= req_len;
      r_q_data[w_wr_idx]   <= req_op ? '0 : r_mem[w_word_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < p_depth; i++) begin
        r_q_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < p_depth; i++) begin
        if (r_q_cnt[i] != 3'd0) begin
          r_q_cnt[i] <= r_q_cnt[i] - 3'd1;
        end
      end
      if (w_push) begin
        r_q_cnt[w_wr_idx] <= LOAD_CNT;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table for read/write semantics plus
// sequences for backpressure, reset mid-flight and latency-1 streaming.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_val, req_rdy, req_op;
  logic [7:0]  req_opaque;
  logic [31:0] req_addr;
  logic [1:0]  req_len;
  logic [31:0] req_data;
  logic        resp_val, resp_rdy, resp_op;
  logic [7:0]  resp_opaque;
  logic [31:0] resp_addr;
  logic [1:0]  resp_len;
  logic [31:0] resp_data;

  logic        s_req_val, s_req_rdy, s_req_op;
  logic [7:0]  s_req_opaque;
  logic [31:0] s_req_addr;
  logic [1:0]  s_req_len;
  logic [31:0] s_req_data;
  logic        s_resp_val, s_resp_rdy, s_resp_op;
  logic [7:0]  s_resp_opaque;
  logic [31:0] s_resp_addr;
  logic [1:0]  s_resp_len;
  logic [31:0] s_resp_data;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_responder u_dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op), .req_opaque(req_opaque),
    .req_addr(req_addr), .req_len(req_len), .req_data(req_data),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_op(resp_op), .resp_opaque(resp_opaque),
    .resp_addr(resp_addr), .resp_len(resp_len), .resp_data(resp_data)
  );

  mem_responder #(.p_latency(1), .p_depth(2)) u_dut_stream (
    .clk(clk), .rst(rst),
    .req_val(s_req_val), .req_rdy(s_req_rdy), .req_op(s_req_op), .req_opaque(s_req_opaque),
    .req_addr(s_req_addr), .req_len(s_req_len), .req_data(s_req_data),
    .resp_val(s_resp_val), .resp_rdy(s_resp_rdy), .resp_op(s_resp_op), .resp_opaque(s_resp_opaque),
    .resp_addr(s_resp_addr), .resp_len(s_resp_len), .resp_data(s_resp_data)
  );

  typedef struct {
    logic        op;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  initial begin
    logic [31:0] s_exp_data [8];
    logic [7:0]  exp_tag;
    int          stale;

    vecs[0]  = '{1'b1, 8'h05, 32'h10,  2'd0, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 8'h06, 32'h10,  2'd0, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 8'h07, 32'h20,  2'd0, 32'h11223344, 32'h0};
    vecs[3]  = '{1'b1, 8'h08, 32'h20,  2'd1, 32'hFFFFFFAA, 32'h0};
    vecs[4]  = '{1'b0, 8'h09, 32'h20,  2'd0, 32'h0,        32'h112233AA};
    vecs[5]  = '{1'b1, 8'h0A, 32'h20,  2'd2, 32'h5555BBCC, 32'h0};
    vecs[6]  = '{1'b0, 8'h0B, 32'h20,  2'd0, 32'h0,        32'h1122BBCC};
    vecs[7]  = '{1'b1, 8'h0C, 32'h20,  2'd3, 32'h99DDEEFF, 32'h0};
    vecs[8]  = '{1'b0, 8'h0D, 32'h22,  2'd0, 32'h0,        32'h11DDEEFF};
    vecs[9]  = '{1'b1, 8'h0E, 32'h0,   2'd0, 32'hCAFEF00D, 32'h0};
    vecs[10] = '{1'b0, 8'h0F, 32'h400, 2'd0, 32'h0,        32'hCAFEF00D};
    vecs[11] = '{1'b0, 8'h10, 32'h10,  2'd0, 32'h0,        32'hDEADBEEF};

    rst = 1'b0;
    req_val = 1'b0; req_op = 1'b0; req_opaque = '0; req_addr = '0; req_len = '0; req_data = '0;
    resp_rdy = 1'b1;
    s_req_val = 1'b0; s_req_op = 1'b0; s_req_opaque = '0; s_req_addr = '0; s_req_len = '0;
    s_req_data = '0; s_resp_rdy = 1'b1;

    repeat (2) @(negedge clk);
    check("reset_req_rdy", req_rdy, 0);
    check("reset_resp_val", resp_val, 0);
    rst = 1'b1;
    #1;
    check("rdy_after_reset", req_rdy, 1);

    // Each vector: accept, confirm no response one cycle later, then check the response.
    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      req_val = 1'b1; req_op = vecs[v].op; req_opaque = vecs[v].opaque;
      req_addr = vecs[v].addr; req_len = vecs[v].len; req_data = vecs[v].data;
      check($sformatf("v%0d_req_rdy", v), req_rdy, 1);
      @(negedge clk);
      req_val = 1'b0;
      check($sformatf("v%0d_not_early", v), resp_val, 0);
      @(negedge clk);
      check($sformatf("v%0d_resp_val", v), resp_val, 1);
      check($sformatf("v%0d_op", v), resp_op, vecs[v].op);
      check($sformatf("v%0d_opaque", v), resp_opaque, vecs[v].opaque);
      check($sformatf("v%0d_addr", v), resp_addr, vecs[v].addr);
      check($sformatf("v%0d_len", v), resp_len, vecs[v].len);
      check($sformatf("v%0d_data", v), resp_data, vecs[v].exp_data);
    end

    // Backpressure: five reads into a four-entry queue.
    @(negedge clk);
    resp_rdy = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      req_val = 1'b1; req_op = 1'b0; req_opaque = 8'(k); req_addr = 32'h10; req_len = 2'd0;
      check($sformatf("bp_accept%0d", k), req_rdy, (k <= 4) ? 1 : 0);
      @(negedge clk);
    end
    for (int h = 0; h < 3; h++) begin
      check("bp_hold_val", resp_val, 1);
      check("bp_hold_opaque", resp_opaque, 1);
      check("bp_hold_data", resp_data, 32'hDEADBEEF);
      check("bp_hold_rdy", req_rdy, 0);
      @(negedge clk);
    end
    resp_rdy = 1'b1;
    check("bp_no_bypass", req_rdy, 0);
    @(negedge clk);
    check("bp_rdy_rise", req_rdy, 1);
    check("bp_second", resp_opaque, 2);
    @(negedge clk);
    req_val = 1'b0;
    exp_tag = 8'd3;
    for (int c = 0; c < 10 && exp_tag <= 8'd5; c++) begin
      if (resp_val) begin
        check("bp_order", resp_opaque, exp_tag);
        exp_tag++;
      end
      @(negedge clk);
    end
    check("bp_drain_last", exp_tag, 6);
    check("bp_empty", resp_val, 0);

    // Reset pulse with three responses in flight.
    resp_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_val = 1'b1; req_op = 1'b0; req_opaque = 8'(8'h20 + k); req_addr = 32'h10;
      @(negedge clk);
    end
    req_val = 1'b0;
    @(negedge clk);
    check("rst_pre_val", resp_val, 1);
    #2 rst = 1'b0;
    #1;
    check("rst_val_clear", resp_val, 0);
    check("rst_rdy_low", req_rdy, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_rdy_release", req_rdy, 1);
    resp_rdy = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (resp_val) stale++;
    end
    check("rst_no_stale", stale, 0);

    // Latency-1 streaming: four writes then four read-backs, one per cycle.
    for (int n = 0; n <= 8; n++) begin
      @(negedge clk);
      if (n > 0) begin
        check($sformatf("st%0d_val", n - 1), s_resp_val, 1);
        check($sformatf("st%0d_opaque", n - 1), s_resp_opaque, 8'h40 + 8'(n - 1));
        check($sformatf("st%0d_data", n - 1), s_resp_data, s_exp_data[n - 1]);
        check($sformatf("st%0d_rdy", n - 1), s_req_rdy, 1);
      end
      if (n < 8) begin
        s_req_val = 1'b1;
        s_req_opaque = 8'h40 + 8'(n);
        s_req_len = 2'd0;
        if (n < 4) begin
          s_req_op = 1'b1; s_req_addr = 32'(4 * n); s_req_data = 32'hA0000000 + 32'(n);
          s_exp_data[n] = 32'h0;
        end else begin
          s_req_op = 1'b0; s_req_addr = 32'(4 * (n - 4)); s_req_data = '0;
          s_exp_data[n] = 32'hA0000000 + 32'(n - 4);
        end
      end else begin
        s_req_val = 1'b0;
      end
    end
    @(negedge clk);
    check("st_drained", s_resp_val, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
